// File: rtl/tx_scheduler.sv
// tx_scheduler: frame-level sequencer for the XGMII TX0 frame generator.
// Chooses when an ARP request, IPv4 frame or IPv6 frame starts, enforces the
// inter-frame gap, resolves the next-hop MAC through ARP with timeout/retry
// and publishes per-second frame and byte rates.
// Optional feature macro: TX_SCHED_ARP_EN (ARP resolution path present).
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   tx_enable, tx_ipv6, tx_req_arp run control and frame selection
//   tx_frame_len, tx_inter_frame_gap frame bytes (incl. FCS), idle gap cycles
//   sec_oneshot                   once-per-second stats publish pulse
//   arp_reply_valid/arp_reply_mac ARP reply from the RX parser
//   gen_done / gen_start, gen_kind generator handshake
//   tx_dst_mac, arp_resolved, arp_fail next-hop MAC status
//   tx_pps, tx_throughput         published per-second statistics
//   tx_state                      debug view of the sequencer state
module tx_scheduler #(
  parameter logic [23:0] ARP_TIMEOUT   = 24'd156250,
  parameter logic [1:0]  ARP_RETRY_MAX = 2'd3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tx_enable,
  input  logic        tx_ipv6,
  input  logic        tx_req_arp,
  input  logic [15:0] tx_frame_len,
  input  logic [31:0] tx_inter_frame_gap,
  input  logic        sec_oneshot,
  input  logic        arp_reply_valid,
  input  logic [47:0] arp_reply_mac,
  input  logic        gen_done,
  output logic        gen_start,
  output logic [1:0]  gen_kind,
  output logic [47:0] tx_dst_mac,
  output logic        arp_resolved,
  output logic        arp_fail,
  output logic [31:0] tx_pps,
  output logic [31:0] tx_throughput,
  output logic [2:0]  tx_state
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    REQ_ARP     = 3'd0,
    WAIT_ARPREP = 3'd1,
    V4_SEND     = 3'd2,
    V6_SEND     = 3'd3,
    GAP         = 3'd4,
    IDLE        = 3'd5
  } state_t;

  localparam logic [1:0] KIND_ARP = 2'b00;
  localparam logic [1:0] KIND_V4  = 2'b01;
  localparam logic [1:0] KIND_V6  = 2'b10;

  state_t             state;
  logic [CNT_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   frame_nxt;
  logic [CNT_W-1:0]   byte_nxt;
  logic [CNT_W:0]     byte_sum;
  logic               frame_done;
  state_t             launch_state;
  logic [1:0]         launch_kind;

  assign tx_state     = state;
  assign launch_state = tx_ipv6 ? V6_SEND : V4_SEND;
  assign launch_kind  = tx_ipv6 ? KIND_V6 : KIND_V4;

  // Only data frames count; ARP frames complete in REQ_ARP.
  assign frame_done = gen_done && ((state == V4_SEND) || (state == V6_SEND));
  assign byte_sum   = {1'b0, byte_cnt} + (CNT_W+1)'(tx_frame_len);

  // Saturating next values of the running counters.
  always_comb begin
    frame_nxt = frame_cnt;
    byte_nxt  = byte_cnt;
    if (frame_done) begin
      frame_nxt = (frame_cnt == '1) ? frame_cnt : frame_cnt + CNT_W'(1);
      byte_nxt  = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
    end
  end

`ifdef TX_SCHED_ARP_EN
  logic [23:0] timer;
  logic [1:0]  retry;
`else
  logic unused_arp;
  assign unused_arp   = ^{tx_req_arp, arp_reply_valid, arp_reply_mac,
                          ARP_TIMEOUT, ARP_RETRY_MAX};
  assign tx_dst_mac   = '1;
  assign arp_resolved = 1'b0;
  assign arp_fail     = 1'b0;
`endif

  // Sequencer: state, generator handshake and ARP bookkeeping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      gen_start <= 1'b0;
      gen_kind  <= KIND_ARP;
      gap_cnt   <= '0;
`ifdef TX_SCHED_ARP_EN
      timer        <= '0;
      retry        <= '0;
      tx_dst_mac   <= '1;
      arp_resolved <= 1'b0;
      arp_fail     <= 1'b0;
`endif
    end else begin
      gen_start <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_enable) begin
`ifdef TX_SCHED_ARP_EN
            if (tx_req_arp && !arp_resolved && !arp_fail) begin
              state     <= REQ_ARP;
              gen_start <= 1'b1;
              gen_kind  <= KIND_ARP;
              retry     <= '0;
            end else begin
              state     <= launch_state;
              gen_start <= 1'b1;
              gen_kind  <= launch_kind;
            end
`else
            state     <= launch_state;
            gen_start <= 1'b1;
            gen_kind  <= launch_kind;
`endif
          end
        end
`ifdef TX_SCHED_ARP_EN
        REQ_ARP: begin
          if (gen_done) begin
            state <= WAIT_ARPREP;
            timer <= ARP_TIMEOUT;
          end
        end
        WAIT_ARPREP: begin
          // Reply is checked before the timeout so a coinciding reply wins.
          if (!tx_enable) begin
            state <= IDLE;
          end else if (arp_reply_valid) begin
            tx_dst_mac   <= arp_reply_mac;
            arp_resolved <= 1'b1;
            state        <= launch_state;
            gen_start    <= 1'b1;
            gen_kind     <= launch_kind;
          end else if (timer == '0) begin
            if (retry < ARP_RETRY_MAX) begin
              state     <= REQ_ARP;
              gen_start <= 1'b1;
              gen_kind  <= KIND_ARP;
              retry     <= retry + 2'd1;
            end else begin
              arp_fail <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            timer <= timer - 24'd1;
          end
        end
`endif
        V4_SEND, V6_SEND: begin
          if (gen_done) begin
            if (tx_inter_frame_gap == '0) begin
              if (tx_enable) begin
                state     <= launch_state;
                gen_start <= 1'b1;
                gen_kind  <= launch_kind;
              end else begin
                state <= IDLE;
              end
            end else begin
              state   <= GAP;
              gap_cnt <= tx_inter_frame_gap;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - CNT_W'(1);
          if (!tx_enable) begin
            state <= IDLE;
          end else if (gap_cnt == CNT_W'(1)) begin
            state     <= launch_state;
            gen_start <= 1'b1;
            gen_kind  <= launch_kind;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef TX_SCHED_ARP_EN
      if (!tx_req_arp) arp_resolved <= 1'b0;
      if (!tx_enable)  arp_fail     <= 1'b0;
`endif
    end
  end

  // Per-second statistics; a completion on the publish cycle is included.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt     <= '0;
      byte_cnt      <= '0;
      tx_pps        <= '0;
      tx_throughput <= '0;
    end else if (sec_oneshot) begin
      tx_pps        <= frame_nxt;
      tx_throughput <= byte_nxt;
      frame_cnt     <= '0;
      byte_cnt      <= '0;
    end else begin
      frame_cnt <= frame_nxt;
      byte_cnt  <= byte_nxt;
    end
  end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Frame-level sequencer for the XGMII TX0 frame generator. It decides when the generator emits an ARP request, an IPv4 frame or an IPv6 frame, and enforces the inter-frame gap. It also resolves the next-hop MAC through ARP with timeout and retry, and publishes per-second TX packet and byte rates to the PCI user registers. It sits between the PCI register block and the 64-bit XGMII frame generator, in the 156.25 MHz sys_clk domain.

## Interface
- ARP_TIMEOUT, 24'd156250: cycles to wait for an ARP reply (1 ms).
- ARP_RETRY_MAX, 2'd3: ARP re-requests issued after the first before giving up.
- sys_clk  in  1  156.25 MHz clock; the only clock.
- sys_rst_n  in  1  reset, asynchronous and active-low.
- tx_enable  in  1  run/stop from the PCI register.
- tx_ipv6  in  1  1 = IPv6 frames, 0 = IPv4 frames.
- tx_req_arp  in  1  resolve the gateway MAC before sending.
- tx_frame_len  in  16  frame bytes including FCS.
- tx_inter_frame_gap  in  32  idle cycles between frames.
- sec_oneshot  in  1  one-cycle pulse once per second.
- arp_reply_valid  in  1  one-cycle pulse from the RX parser.
- arp_reply_mac  in  48  sender MAC; valid with arp_reply_valid.
- gen_done  in  1  one-cycle pulse: generator finished the current frame (FCS and terminate sent).
- gen_start  out  1  one-cycle pulse: generator begins a frame.
- gen_kind  out  2  00 = ARP, 01 = IPv4, 10 = IPv6; held stable from gen_start until gen_done.
- tx_dst_mac  out  48  resolved destination MAC.
- arp_resolved  out  1  tx_dst_mac is valid.
- arp_fail  out  1  sticky flag: retries exhausted.
- tx_pps  out  32  frames completed in the last second.
- tx_throughput  out  32  bytes completed in the last second.
- tx_state  out  3  current state, for debug.

## Operation
- State encoding: REQ_ARP = 0, WAIT_ARPREP = 1, V4_SEND = 2, V6_SEND = 3, GAP = 4, IDLE = 5.
- **Launch** (one shared action, used by several transitions):
  - Go to V6_SEND if tx_ipv6 = 1, otherwise V4_SEND.
  - Assert gen_start and set gen_kind on the same edge.
  - tx_ipv6 is sampled only at launch.
- **IDLE**, with tx_enable = 1:
  - If tx_req_arp = 1, arp_resolved = 0 and arp_fail = 0: go to REQ_ARP with gen_start, gen_kind = 00, retry = 0.
  - Otherwise: launch.
- **REQ_ARP**:
  - On gen_done: go to WAIT_ARPREP and load timer = ARP_TIMEOUT.
- **WAIT_ARPREP**:
  - If tx_enable = 0: go to IDLE.
  - On arp_reply_valid: latch tx_dst_mac, set arp_resolved, then launch.
  - On timer = 0 with retry < ARP_RETRY_MAX: go to REQ_ARP with gen_start, retry + 1.
  - On timer = 0 with retries exhausted: set arp_fail, go to IDLE.
  - A reply arriving in the same cycle as the timeout wins.
- **V4_SEND / V6_SEND**:
  - On gen_done: frame_cnt + 1 and byte_cnt + tx_frame_len, both saturating at 32'hFFFFFFFF.
  - If gap = 0: launch when tx_enable = 1, otherwise go to IDLE.
  - If gap ≠ 0: go to GAP with gap_cnt = gap.
  - A frame in flight always completes; tx_enable is ignored in these states.
- **GAP**:
  - Decrement gap_cnt each cycle.
  - If tx_enable = 0: go to IDLE immediately.
  - At gap_cnt = 1: launch.
- gen_done is ignored in IDLE, WAIT_ARPREP and GAP.
- ARP frames are never counted in frame_cnt or byte_cnt.
- arp_resolved clears whenever tx_req_arp = 0; tx_dst_mac keeps its last value.
- arp_fail clears whenever tx_enable = 0.
- **sec_oneshot**:
  - tx_pps <= frame_cnt and tx_throughput <= byte_cnt.
  - The counters restart at 0.
  - If a completion lands on the same cycle, it is included in the published value and the counters restart at 0.

## Timing
- Reset values:
  - tx_state = IDLE.
  - gen_start = 0, gen_kind = 00.
  - tx_dst_mac = 48'hFFFFFFFFFFFF.
  - arp_resolved = 0, arp_fail = 0.
  - tx_pps = 0, tx_throughput = 0.
  - All internal counters = 0.
- All outputs are registered.
- gen_start is high exactly one cycle, on the same edge tx_state enters the new state.
- tx_enable sampled high in IDLE at edge N produces gen_start high in cycle N+1.
- gen_done at edge N leaves SEND at N. The next gen_start follows after exactly tx_inter_frame_gap GAP cycles; with gap = 0 it is at N+1, with no idle cycle.
- Stats update one cycle after the sec_oneshot edge.
- Reset asserted mid-frame aborts immediately. The generator is reset by the same sys_rst_n.

## Configuration
- TX_SCHED_ARP_EN defined: ARP path present as described.
- TX_SCHED_ARP_EN undefined:
  - REQ_ARP and WAIT_ARPREP are removed and IDLE always launches.
  - tx_req_arp, arp_reply_valid and arp_reply_mac are ignored.
  - arp_resolved = 0, arp_fail = 0, tx_dst_mac constant 48'hFFFFFFFFFFFF.

## Test plan
- IPv4 launch: tx_enable = 1, tx_ipv6 = 0, gap = 3, generator answers gen_done 8 cycles after gen_start -> gen_kind = 01 and consecutive gen_start pulses exactly 12 cycles apart.
- ARP success: tx_req_arp = 1, reply with MAC 00:37:76:00:01:01 arrives 100 cycles after the ARP gen_done -> tx_dst_mac = 48'h003776000101, arp_resolved = 1, next gen_kind = 01.
- ARP failure: ARP_TIMEOUT = 50, no reply -> exactly 4 ARP gen_start pulses, then arp_fail = 1 and IDLE; dropping tx_enable clears arp_fail.
- Reply and timeout coincide: reply wins -> arp_resolved = 1, no retry issued.
- Stats: frame_len = 64, gap = 0, 10 frames, then sec_oneshot on the same cycle as the 11th gen_done -> tx_pps = 11, tx_throughput = 704, counters restart at 0.
- Stop and reset: tx_enable dropped mid-frame -> frame completes, then IDLE; tx_enable dropped in GAP -> IDLE next cycle; sys_rst_n asserted mid-frame -> all outputs at reset values asynchronously.
